// File: rtl/rv64i_fetch_stage_if.sv
// Fetch-stage bundle: BRAM read port, decode handshake (stall/valid) and EX redirect.
// master = fetch stage, slave = surrounding pipeline / memory.
interface rv64i_fetch_stage_if #(
    parameter int PC_W    = 64,
    parameter int IMEM_AW = 9
);
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic               id_stall;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic [31:0]        if_ins;
    logic [PC_W-1:0]    if_pc;
    logic [PC_W-1:0]    if_pc_plus1;
    logic               if_valid;

    modport master (
        output imem_addr, if_ins, if_pc, if_pc_plus1, if_valid,
        input  imem_rdata, id_stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_addr, if_ins, if_pc, if_pc_plus1, if_valid,
        output imem_rdata, id_stall, redirect, redirect_pc
    );
endinterface

// File: rtl/rv64i_fetch_stage.sv
// RV64I fetch: word PC driving a 1-cycle BRAM, 1 instr/cycle, redirect visible next cycle.
// id_stall freezes PC and outputs via a one-entry hold buffer; redirect beats stall and squashes ID.
module rv64i_fetch_stage #(
    parameter int              PC_W     = 64,
    parameter int              IMEM_AW  = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP_INS  = 32'h00000013
) (
    input  logic                clk,
    input  logic                rst_n,
    rv64i_fetch_stage_if.master bus
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] out_pc;
    logic            out_valid;
    logic [31:0]     hold_ins;
    logic            hold_valid;
    logic            valid_now;

    always_comb begin
        bus.imem_addr = pc_q[IMEM_AW-1:0];
        if (!rst_n) begin
            bus.imem_addr = RESET_PC[IMEM_AW-1:0];
        end else if (bus.redirect) begin
            bus.imem_addr = bus.redirect_pc[IMEM_AW-1:0];
        end
    end

    // A redirect squashes whatever is sitting in ID this cycle.
    assign valid_now       = rst_n & out_valid & ~bus.redirect;
    assign bus.if_valid    = valid_now;
    assign bus.if_ins      = !valid_now ? NOP_INS : (hold_valid ? hold_ins : bus.imem_rdata);
    assign bus.if_pc       = out_pc;
    assign bus.if_pc_plus1 = out_pc + PC_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            out_pc     <= RESET_PC;
            out_valid  <= 1'b0;
            hold_valid <= 1'b0;
            hold_ins   <= NOP_INS;
        end else if (bus.redirect) begin
            pc_q       <= bus.redirect_pc + PC_W'(1);
            out_pc     <= bus.redirect_pc;
            out_valid  <= 1'b1;
            hold_valid <= 1'b0;
        end else if (bus.id_stall) begin
            // Capture only on the first stall cycle; later BRAM data belongs to pc_q.
            if (!hold_valid) begin
                hold_ins   <= bus.imem_rdata;
                hold_valid <= 1'b1;
            end
        end else begin
            pc_q       <= pc_q + PC_W'(1);
            out_pc     <= pc_q;
            out_valid  <= 1'b1;
            hold_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rv64i_fetch_stage.sv
// Directed bench for rv64i_fetch_stage: stream, stall, redirect, wrap and mid-run reset.
module tb_rv64i_fetch_stage;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    logic [31:0] mem [512];

    rv64i_fetch_stage_if #(.PC_W(64), .IMEM_AW(9)) b ();

    rv64i_fetch_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read instruction BRAM model.
    always @(posedge clk) b.imem_rdata <= mem[b.imem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [63:0] pc, input logic [31:0] ins);
        chk({tag, " valid"}, 64'(b.if_valid), 64'd1);
        chk({tag, " pc"}, b.if_pc, pc);
        chk({tag, " ins"}, 64'(b.if_ins), 64'(ins));
        chk({tag, " pc+1"}, b.if_pc_plus1, pc + 64'd1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 512; i++) mem[i] = 32'h100 + i;
        b.imem_rdata  = 32'h0;
        b.id_stall    = 1'b0;
        b.redirect    = 1'b0;
        b.redirect_pc = 64'h0;
        rst_n         = 1'b0;

        // 1. reset and stream
        repeat (3) begin
            tick();
            settle();
            chk("rst valid", 64'(b.if_valid), 64'd0);
            chk("rst addr", 64'(b.imem_addr), 64'd0);
            chk("rst ins", 64'(b.if_ins), 64'h13);
        end
        tick();
        rst_n = 1'b1;
        settle();
        chk("first cycle valid", 64'(b.if_valid), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            settle();
            chk_out("stream", 64'(i), 32'h100 + 32'(i));
        end

        // 2. stall at pc 5 for 3 cycles, then release
        tick();
        b.id_stall = 1'b1;
        settle();
        chk_out("stall0", 64'h5, 32'h105);
        chk("stall0 addr", 64'(b.imem_addr), 64'h6);
        for (int i = 0; i < 2; i++) begin
            tick();
            settle();
            chk_out("stallN", 64'h5, 32'h105);
            chk("stallN addr", 64'(b.imem_addr), 64'h6);
        end
        tick();
        b.id_stall = 1'b0;
        settle();
        chk_out("release", 64'h5, 32'h105);
        chk("release addr", 64'(b.imem_addr), 64'h6);
        tick();
        settle();
        chk_out("after release", 64'h6, 32'h106);
        tick();
        settle();
        chk_out("after release2", 64'h7, 32'h107);

        // 3. redirect at pc 8 to 0x20
        tick();
        b.redirect    = 1'b1;
        b.redirect_pc = 64'h20;
        settle();
        chk("redir pc", b.if_pc, 64'h8);
        chk("redir valid", 64'(b.if_valid), 64'd0);
        chk("redir ins", 64'(b.if_ins), 64'h13);
        chk("redir addr", 64'(b.imem_addr), 64'h20);
        tick();
        b.redirect = 1'b0;
        settle();
        chk_out("redir target", 64'h20, 32'h120);
        tick();
        settle();
        chk_out("redir target+1", 64'h21, 32'h121);

        // 4. redirect in second stall cycle discards the hold
        tick();
        b.id_stall = 1'b1;
        settle();
        chk_out("stall pre-redir", 64'h22, 32'h122);
        tick();
        b.redirect    = 1'b1;
        b.redirect_pc = 64'h40;
        settle();
        chk("stall redir valid", 64'(b.if_valid), 64'd0);
        chk("stall redir addr", 64'(b.imem_addr), 64'h40);
        tick();
        b.redirect = 1'b0;
        b.id_stall = 1'b0;
        settle();
        chk_out("stall redir target", 64'h40, 32'h140);
        tick();
        settle();
        chk_out("stall redir target+1", 64'h41, 32'h141);

        // 5. wrap of the memory index and of the full PC
        tick();
        b.redirect    = 1'b1;
        b.redirect_pc = 64'h1FF;
        tick();
        b.redirect = 1'b0;
        settle();
        chk_out("at 1ff", 64'h1FF, 32'h2FF);
        chk("alias addr", 64'(b.imem_addr), 64'h0);
        tick();
        settle();
        chk_out("at 200", 64'h200, 32'h100);
        tick();
        b.redirect    = 1'b1;
        b.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        b.redirect = 1'b0;
        settle();
        chk("max pc", b.if_pc, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("max pc+1", b.if_pc_plus1, 64'h0);
        chk("max ins", 64'(b.if_ins), 64'h2FF);
        tick();
        settle();
        chk_out("pc wrap", 64'h0, 32'h100);

        // 6. reset during a stall at 0x33
        tick();
        b.redirect    = 1'b1;
        b.redirect_pc = 64'h33;
        tick();
        b.redirect = 1'b0;
        b.id_stall = 1'b1;
        settle();
        chk_out("pre-reset stall", 64'h33, 32'h133);
        tick();
        settle();
        chk_out("pre-reset stall2", 64'h33, 32'h133);
        tick();
        rst_n = 1'b0;
        settle();
        chk("mid rst valid", 64'(b.if_valid), 64'd0);
        chk("mid rst addr", 64'(b.imem_addr), 64'd0);
        tick();
        rst_n      = 1'b1;
        b.id_stall = 1'b0;
        settle();
        chk("restart valid", 64'(b.if_valid), 64'd0);
        tick();
        settle();
        chk_out("restart", 64'h0, 32'h100);
        tick();
        settle();
        chk_out("restart+1", 64'h1, 32'h101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
